// File: rtl/arrow_pkg.sv
// Shared definitions for the PS/2 arrow-key decoder.
//  - SC_LEFT/SC_DOWN/SC_RIGHT/SC_UP : full 16-bit extended scancodes of the arrow keys
//  - dir_t : 2-bit direction code reported by the tracker (0=left, 1=down, 2=right, 3=up)
package arrow_pkg;

   localparam logic [15:0] SC_LEFT  = 16'hE06B;
   localparam logic [15:0] SC_DOWN  = 16'hE072;
   localparam logic [15:0] SC_RIGHT = 16'hE074;
   localparam logic [15:0] SC_UP    = 16'hE075;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_RIGHT = 2'd2,
      DIR_UP    = 2'd3
   } dir_t;

endpackage

// File: rtl/arrow_tracker.sv
// Records the most recent arrow key and counts clock edges on which an arrow was held.
// Ports:
//  - clk       : rising-edge clock
//  - reset     : asynchronous active-high clear of all registers
//  - left/down/right/up : one-hot arrow flags from the combinational decoder
//  - last_dir  : code of the most recent arrow (dir_t encoding)
//  - last_vld  : set once any arrow has been sampled since reset
//  - arrow_cnt : saturating count of edges with an arrow active
module arrow_tracker
   import arrow_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             left,
   input  logic             down,
   input  logic             right,
   input  logic             up,
   output logic [1:0]       last_dir,
   output logic             last_vld,
   output logic [CNT_W-1:0] arrow_cnt
);

   logic arrow_seen;
   dir_t next_dir;
   dir_t dir_q;

   assign arrow_seen = left | down | right | up;

   // The flags are one-hot, so a simple priority chain yields the active direction;
   // left is the fall-through value and is only stored when arrow_seen is high.
   always_comb begin
      next_dir = DIR_LEFT;
      if (down) begin
         next_dir = DIR_DOWN;
      end else if (right) begin
         next_dir = DIR_RIGHT;
      end else if (up) begin
         next_dir = DIR_UP;
      end
   end

   // Registers update only on edges with an arrow present; the counter stops at all-ones
   // so a long key hold never wraps back to a small value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dir_q     <= DIR_LEFT;
         last_vld  <= 1'b0;
         arrow_cnt <= '0;
      end else if (arrow_seen) begin
         dir_q    <= next_dir;
         last_vld <= 1'b1;
         if (arrow_cnt != {CNT_W{1'b1}}) begin
            arrow_cnt <= arrow_cnt + CNT_W'(1);
         end
      end
   end

   assign last_dir = dir_q;

endmodule

// File: rtl/top_module_arrow_decoder.sv
// Decodes an assembled PS/2 extended scancode into one-hot arrow-key flags and tracks
// arrow activity for the keyboard status logic.
// Ports:
//  - clk, reset : clock and asynchronous active-high reset (reset affects tracker only)
//  - scancode   : 16-bit assembled scancode, may change at any time
//  - left/down/right/up : combinational exact-match flags, at most one high
//  - arrow_any  : OR of the four flags
//  - last_dir, last_vld, arrow_cnt : registered tracker outputs, one cycle behind scancode
module top_module_arrow_decoder
   import arrow_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      scancode,
   output logic             left,
   output logic             down,
   output logic             right,
   output logic             up,
   output logic             arrow_any,
   output logic [1:0]       last_dir,
   output logic             last_vld,
   output logic [CNT_W-1:0] arrow_cnt
);

   // Exact 16-bit compare; every flag starts at 0 so unmatched (or unknown) codes give
   // all-zero flags. The decode deliberately ignores reset.
   always_comb begin
      left  = 1'b0;
      down  = 1'b0;
      right = 1'b0;
      up    = 1'b0;
      case (scancode)
         SC_LEFT:  left  = 1'b1;
         SC_DOWN:  down  = 1'b1;
         SC_RIGHT: right = 1'b1;
         SC_UP:    up    = 1'b1;
         default:  ;
      endcase
   end

   assign arrow_any = left | down | right | up;

   arrow_tracker #(
      .CNT_W (CNT_W)
   ) u_tracker (
      .clk       (clk),
      .reset     (reset),
      .left      (left),
      .down      (down),
      .right     (right),
      .up        (up),
      .last_dir  (last_dir),
      .last_vld  (last_vld),
      .arrow_cnt (arrow_cnt)
   );

endmodule

// File: tb/tb_top_module_arrow_decoder.sv
// Directed and random checks of top_module_arrow_decoder. A second instance with a
// 2-bit counter exercises saturation.
module tb_top_module_arrow_decoder;

   logic        clk;
   logic        reset;
   logic [15:0] scancode;
   logic        left, down, right, up, arrow_any;
   logic [1:0]  last_dir;
   logic        last_vld;
   logic [15:0] arrow_cnt;

   logic        reset2;
   logic [15:0] scancode2;
   logic        left2, down2, right2, up2, arrow_any2;
   logic [1:0]  last_dir2;
   logic        last_vld2;
   logic [1:0]  arrow_cnt2;

   int vectors;
   int miscompares;

   top_module_arrow_decoder #(.CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .scancode  (scancode),
      .left      (left),
      .down      (down),
      .right     (right),
      .up        (up),
      .arrow_any (arrow_any),
      .last_dir  (last_dir),
      .last_vld  (last_vld),
      .arrow_cnt (arrow_cnt)
   );

   top_module_arrow_decoder #(.CNT_W(2)) dut2 (
      .clk       (clk),
      .reset     (reset2),
      .scancode  (scancode2),
      .left      (left2),
      .down      (down2),
      .right     (right2),
      .up        (up2),
      .arrow_any (arrow_any2),
      .last_dir  (last_dir2),
      .last_vld  (last_vld2),
      .arrow_cnt (arrow_cnt2)
   );

   // Free-running clock, period 10, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives a new scancode onto the main instance and lets the decode settle.
   task automatic applyStimulus(input logic [15:0] code);
      scancode = code;
      #1;
   endtask

   // One comparison: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference decode written directly from the four arrow codes; returns {up,left,down,right,any}.
   function automatic logic [4:0] modelFlags(input logic [15:0] code);
      logic u, l, d, r;
      u = (code == 16'hE075);
      l = (code == 16'hE06B);
      d = (code == 16'hE072);
      r = (code == 16'hE074);
      return {u, l, d, r, (u | l | d | r)};
   endfunction

   logic [15:0] sweep_codes [9];
   logic [4:0]  sweep_exp   [9];
   logic [15:0] near_codes  [5];
   logic [15:0] arrow_tab   [4];

   // Directed sequence followed by the random sweep; everything runs in this one block.
   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      reset2      = 1'b1;
      scancode    = 16'h0000;
      scancode2   = 16'h0000;

      sweep_codes = '{16'h0000, 16'h0001, 16'hE075, 16'hE06B, 16'hE06C,
                      16'hE072, 16'hE074, 16'hE076, 16'hFFFF};
      // {up,left,down,right,arrow_any}
      sweep_exp   = '{5'b00000, 5'b00000, 5'b10001, 5'b01001, 5'b00000,
                      5'b00101, 5'b00011, 5'b00000, 5'b00000};
      near_codes  = '{16'h006B, 16'hE16B, 16'hE0EB, 16'h0E07, 16'hE007};
      arrow_tab   = '{16'hE06B, 16'hE072, 16'hE074, 16'hE075};

      $display("[TB] reset state and decode sweep with reset held");
      @(negedge clk);
      checkOutput("rst_last_dir", 32'(last_dir), 32'd0);
      checkOutput("rst_last_vld", 32'(last_vld), 32'd0);
      checkOutput("rst_arrow_cnt", 32'(arrow_cnt), 32'd0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(sweep_codes[i]);
         checkOutput($sformatf("sweep_%h", sweep_codes[i]),
                     32'({up, left, down, right, arrow_any}), 32'(sweep_exp[i]));
      end

      for (int i = 0; i < 5; i++) begin
         applyStimulus(near_codes[i]);
         checkOutput($sformatf("near_%h", near_codes[i]),
                     32'({up, left, down, right, arrow_any}), 32'd0);
      end

      // Registers must not have moved while reset was held, even with arrows present.
      checkOutput("rst_hold_cnt", 32'(arrow_cnt), 32'd0);

      $display("[TB] counting with reset released");
      @(negedge clk);
      applyStimulus(16'hE074);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("right3_dir", 32'(last_dir), 32'd2);
      checkOutput("right3_vld", 32'(last_vld), 32'd1);
      checkOutput("right3_cnt", 32'(arrow_cnt), 32'd3);

      applyStimulus(16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("hold_dir", 32'(last_dir), 32'd2);
      checkOutput("hold_vld", 32'(last_vld), 32'd1);
      checkOutput("hold_cnt", 32'(arrow_cnt), 32'd3);

      applyStimulus(16'hE06B);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("left_dir", 32'(last_dir), 32'd0);
      checkOutput("cnt5", 32'(arrow_cnt), 32'd5);

      $display("[TB] asynchronous reset between edges");
      #2;
      applyStimulus(16'hE072);
      reset = 1'b1;
      #1;
      checkOutput("async_cnt", 32'(arrow_cnt), 32'd0);
      checkOutput("async_vld", 32'(last_vld), 32'd0);
      checkOutput("async_dir", 32'(last_dir), 32'd0);
      checkOutput("rst_flags_down", 32'({up, left, down, right, arrow_any}), 32'b00101);
      applyStimulus(16'hE075);
      checkOutput("rst_flags_up", 32'({up, left, down, right, arrow_any}), 32'b10001);
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_edge_cnt", 32'(arrow_cnt), 32'd0);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("resume_cnt", 32'(arrow_cnt), 32'd1);
      checkOutput("resume_dir", 32'(last_dir), 32'd3);
      checkOutput("resume_vld", 32'(last_vld), 32'd1);

      $display("[TB] saturation with a 2-bit counter");
      scancode2 = 16'hE06B;
      reset2    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_cnt2", 32'(arrow_cnt2), 32'd2);
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("sat_cnt3", 32'(arrow_cnt2), 32'd3);
      checkOutput("sat_dir", 32'(last_dir2), 32'd0);
      checkOutput("sat_vld", 32'(last_vld2), 32'd1);

      $display("[TB] random decode sweep on both clock edges");
      reset = 1'b1;
      for (int n = 0; n < 30000; n++) begin
         logic [15:0] code;
         @(clk);
         code = 16'($urandom);
         // Bias some draws onto the arrow codes so the match paths see real traffic.
         if ((n % 4) == 0) begin
            code = arrow_tab[$urandom_range(0, 3)];
         end
         applyStimulus(code);
         checkOutput("random", 32'({up, left, down, right, arrow_any}),
                     32'(modelFlags(code)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
